// File: rtl/wave_program_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : wave_program_scheduler
// Purpose  : Slot sequencer for the x/y wave-generator pair. Keeps up to
//            NUM_SLOTS x/y programs in a double-buffered store (shadow
//            written by cfg_*, active presented). Rotates through the active
//            slots, one frame per slot. Each frame is one LOAD cycle with the
//            generators held in reset, then FRAME_CYCLES RUN cycles.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, reset       clock, synchronous active-high reset
//   enable           1 = rotate slots, 0 = park generators in reset
//   slot_count       active slot count (0 -> 1, > NUM_SLOTS -> NUM_SLOTS)
//   cfg_we           write one opcode/param entry into the shadow bank
//   cfg_slot/axis/idx  target of the write (axis 0 = x, 1 = y)
//   cfg_instr/param  3-bit opcode and 8-bit parameter written
//   cfg_commit       request a shadow -> active copy
//   x/y_instr_flat   opcodes, entry i at [3i+:3]
//   x/y_params_flat  params, entry i at [8i+:8]
//   gen_reset        reset to both generators
//   cur_slot         slot currently presented
//   frame_start      pulse on the first RUN cycle of each frame
//   commit_pending   commit requested but not yet applied
// ============================================================================
module wave_program_scheduler #(
  parameter int NUM_SLOTS    = 4,
  parameter int FRAME_CYCLES = 1024,
  localparam int SW = $clog2(NUM_SLOTS),
  localparam int TW = $clog2(FRAME_CYCLES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [SW:0]   slot_count,
  input  logic          cfg_we,
  input  logic [SW-1:0] cfg_slot,
  input  logic          cfg_axis,
  input  logic [1:0]    cfg_idx,
  input  logic [2:0]    cfg_instr,
  input  logic [7:0]    cfg_param,
  input  logic          cfg_commit,
  output logic [11:0]   x_instr_flat,
  output logic [31:0]   x_params_flat,
  output logic [11:0]   y_instr_flat,
  output logic [31:0]   y_params_flat,
  output logic          gen_reset,
  output logic [SW-1:0] cur_slot,
  output logic          frame_start,
  output logic          commit_pending
);

  // One slot's program packed as {y_params, y_instr, x_params, x_instr}.
  localparam int PW          = 88;
  localparam int X_INSTR_LSB = 0;
  localparam int X_PARAM_LSB = 12;
  localparam int Y_INSTR_LSB = 44;
  localparam int Y_PARAM_LSB = 56;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  logic [PW-1:0] shadow [NUM_SLOTS];
  logic [PW-1:0] active [NUM_SLOTS];

  state_t        state, state_nx;
  logic [TW-1:0] timer, timer_nx;
  logic [SW-1:0] slot_nx;
  logic [PW-1:0] prog, prog_nx;
  logic          gen_reset_nx;
  logic          frame_start_nx;
  logic          pending_nx;

  logic          at_end;
  logic [SW:0]   eff_count;
  logic [SW:0]   succ;
  logic [SW-1:0] wrap_slot;
  logic [SW-1:0] load_slot;
  logic [PW-1:0] load_prog;
  logic          apply_copy;
  logic [6:0]    instr_off;
  logic [6:0]    param_off;

  assign x_instr_flat  = prog[X_INSTR_LSB +: 12];
  assign x_params_flat = prog[X_PARAM_LSB +: 32];
  assign y_instr_flat  = prog[Y_INSTR_LSB +: 12];
  assign y_params_flat = prog[Y_PARAM_LSB +: 32];

  assign at_end = (state == S_RUN) && (timer == TW'(FRAME_CYCLES - 1));

  always_comb begin
    eff_count = slot_count;
    if (slot_count == '0)
      eff_count = (SW+1)'(1);
    else if (slot_count > (SW+1)'(NUM_SLOTS))
      eff_count = (SW+1)'(NUM_SLOTS);
  end

  // ">=" rather than "==" so a slot_count shrunk below cur_slot+1 wraps to 0.
  assign succ      = {1'b0, cur_slot} + (SW+1)'(1);
  assign wrap_slot = (succ >= eff_count) ? '0 : succ[SW-1:0];

  // A commit lands immediately in IDLE, otherwise only on a boundary that is
  // actually taken (enable low wins over the boundary and leaves it pending).
  assign apply_copy = (commit_pending || cfg_commit) &&
                      ((state == S_IDLE) || (at_end && enable));

  // Flats come from the post-commit bank: on a copy edge the active bank has
  // not been updated yet, so read the (pre-write) shadow directly.
  assign load_slot = (state == S_IDLE) ? '0 : wrap_slot;
  assign load_prog = apply_copy ? shadow[load_slot] : active[load_slot];

  assign instr_off = (cfg_axis ? 7'(Y_INSTR_LSB) : 7'(X_INSTR_LSB)) + 7'(cfg_idx) * 7'd3;
  assign param_off = (cfg_axis ? 7'(Y_PARAM_LSB) : 7'(X_PARAM_LSB)) + 7'(cfg_idx) * 7'd8;

  always_comb begin
    state_nx       = state;
    timer_nx       = timer;
    slot_nx        = cur_slot;
    prog_nx        = prog;
    frame_start_nx = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable) begin
          state_nx = S_LOAD;
          slot_nx  = '0;
          prog_nx  = load_prog;
          timer_nx = '0;
        end
      end
      S_LOAD: begin
        timer_nx = '0;
        if (!enable) begin
          state_nx = S_IDLE;
        end else begin
          state_nx       = S_RUN;
          frame_start_nx = 1'b1;
        end
      end
      S_RUN: begin
        if (!enable) begin
          state_nx = S_IDLE;
          timer_nx = '0;
        end else if (at_end) begin
          state_nx = S_LOAD;
          slot_nx  = wrap_slot;
          prog_nx  = load_prog;
          timer_nx = '0;
        end else begin
          timer_nx = timer + TW'(1);
        end
      end
      default: begin
        state_nx = S_IDLE;
        timer_nx = '0;
      end
    endcase
    gen_reset_nx = (state_nx != S_RUN);
    if (apply_copy)
      pending_nx = 1'b0;
    else if (cfg_commit)
      pending_nx = 1'b1;
    else
      pending_nx = commit_pending;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      timer          <= '0;
      cur_slot       <= '0;
      prog           <= '0;
      gen_reset      <= 1'b1;
      frame_start    <= 1'b0;
      commit_pending <= 1'b0;
    end else begin
      state          <= state_nx;
      timer          <= timer_nx;
      cur_slot       <= slot_nx;
      prog           <= prog_nx;
      gen_reset      <= gen_reset_nx;
      frame_start    <= frame_start_nx;
      commit_pending <= pending_nx;
    end
  end

  // Program banks. The copy reads shadow before this edge's write lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (apply_copy)
        active <= shadow;
      if (cfg_we) begin
        shadow[cfg_slot][instr_off +: 3] <= cfg_instr;
        shadow[cfg_slot][param_off +: 8] <= cfg_param;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wave_program_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_wave_program_scheduler
// Purpose  : Self-checking bench for wave_program_scheduler (4 slots, 8-cycle
//            frames). A behavioural model predicts every cycle's outputs and
//            each frame's program; a monitor compares them against the DUT.
// Revision : 1.0  initial release
// ============================================================================
module tb_wave_program_scheduler;

  localparam int NS = 4;
  localparam int FC = 8;
  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_RUN  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [2:0]  slot_count;
  logic        cfg_we;
  logic [1:0]  cfg_slot;
  logic        cfg_axis;
  logic [1:0]  cfg_idx;
  logic [2:0]  cfg_instr;
  logic [7:0]  cfg_param;
  logic        cfg_commit;
  logic [11:0] x_instr_flat;
  logic [31:0] x_params_flat;
  logic [11:0] y_instr_flat;
  logic [31:0] y_params_flat;
  logic        gen_reset;
  logic [1:0]  cur_slot;
  logic        frame_start;
  logic        commit_pending;

  always #5 clk = ~clk;

  wave_program_scheduler #(.NUM_SLOTS(NS), .FRAME_CYCLES(FC)) dut (
    .clk(clk), .reset(reset), .enable(enable), .slot_count(slot_count),
    .cfg_we(cfg_we), .cfg_slot(cfg_slot), .cfg_axis(cfg_axis), .cfg_idx(cfg_idx),
    .cfg_instr(cfg_instr), .cfg_param(cfg_param), .cfg_commit(cfg_commit),
    .x_instr_flat(x_instr_flat), .x_params_flat(x_params_flat),
    .y_instr_flat(y_instr_flat), .y_params_flat(y_params_flat),
    .gen_reset(gen_reset), .cur_slot(cur_slot), .frame_start(frame_start),
    .commit_pending(commit_pending)
  );

  typedef struct packed {
    logic        gr;
    logic        fs;
    logic        cp;
    logic [1:0]  slot;
    logic [11:0] xi;
    logic [31:0] xp;
    logic [11:0] yi;
    logic [31:0] yp;
  } obs_t;

  typedef struct packed {
    logic [1:0]  slot;
    logic [11:0] xi;
    logic [31:0] xp;
    logic [11:0] yi;
    logic [31:0] yp;
  } frame_t;

  obs_t   stat_q[$];
  frame_t frame_q[$];
  int     checks = 0;
  int     errors = 0;

  // Reference model: banks as [slot][axis][entry] arrays, plus presented program.
  logic [2:0] sh_op [NS][2][4];
  logic [7:0] sh_pr [NS][2][4];
  logic [2:0] ac_op [NS][2][4];
  logic [7:0] ac_pr [NS][2][4];
  logic [2:0] pr_op [2][4];
  logic [7:0] pr_pr [2][4];
  int m_mode, m_timer, m_slot;
  bit m_pend, m_gr, m_fs;

  function automatic obs_t snap();
    obs_t o;
    o.gr = m_gr; o.fs = m_fs; o.cp = m_pend; o.slot = 2'(m_slot);
    for (int i = 0; i < 4; i++) begin
      o.xi[3*i +: 3] = pr_op[0][i];
      o.yi[3*i +: 3] = pr_op[1][i];
      o.xp[8*i +: 8] = pr_pr[0][i];
      o.yp[8*i +: 8] = pr_pr[1][i];
    end
    return o;
  endfunction

  task automatic present(input int s);
    for (int a = 0; a < 2; a++)
      for (int i = 0; i < 4; i++) begin
        pr_op[a][i] = ac_op[s][a][i];
        pr_pr[a][i] = ac_pr[s][a][i];
      end
  endtask

  task automatic model_step();
    bit boundary, do_copy;
    int eff;
    obs_t o;
    frame_t f;
    if (reset) begin
      for (int s = 0; s < NS; s++)
        for (int a = 0; a < 2; a++)
          for (int i = 0; i < 4; i++) begin
            sh_op[s][a][i] = 0; sh_pr[s][a][i] = 0;
            ac_op[s][a][i] = 0; ac_pr[s][a][i] = 0;
          end
      for (int a = 0; a < 2; a++)
        for (int i = 0; i < 4; i++) begin
          pr_op[a][i] = 0; pr_pr[a][i] = 0;
        end
      m_mode = M_IDLE; m_timer = 0; m_slot = 0; m_pend = 0; m_gr = 1; m_fs = 0;
    end else begin
      boundary = (m_mode == M_RUN) && (m_timer == FC - 1);
      do_copy  = (m_pend || cfg_commit) && (m_mode == M_IDLE || (boundary && enable));
      if (do_copy) begin
        ac_op = sh_op;
        ac_pr = sh_pr;
      end
      if (cfg_we) begin
        sh_op[cfg_slot][cfg_axis][cfg_idx] = cfg_instr;
        sh_pr[cfg_slot][cfg_axis][cfg_idx] = cfg_param;
      end
      m_fs = 0;
      if (m_mode == M_IDLE) begin
        if (enable) begin
          m_slot = 0; present(0); m_mode = M_LOAD;
        end
      end else if (!enable) begin
        m_mode = M_IDLE; m_timer = 0;
      end else if (m_mode == M_LOAD) begin
        m_mode = M_RUN; m_timer = 0; m_fs = 1;
      end else if (boundary) begin
        eff = (slot_count == 0) ? 1 : (slot_count > NS) ? NS : int'(slot_count);
        m_slot = (m_slot + 1 >= eff) ? 0 : m_slot + 1;
        present(m_slot); m_mode = M_LOAD; m_timer = 0;
      end else begin
        m_timer++;
      end
      if (do_copy) m_pend = 0;
      else if (cfg_commit) m_pend = 1;
      m_gr = (m_mode != M_RUN);
    end
    o = snap();
    stat_q.push_back(o);
    if (m_fs) begin
      f.slot = o.slot; f.xi = o.xi; f.xp = o.xp; f.yi = o.yi; f.yp = o.yp;
      frame_q.push_back(f);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    obs_t e, a;
    frame_t fe, fa;
    forever begin
      @(posedge clk);
      #1;
      a = '{gen_reset, frame_start, commit_pending, cur_slot,
            x_instr_flat, x_params_flat, y_instr_flat, y_params_flat};
      if (stat_q.size() > 0) begin
        e = stat_q.pop_front();
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL status t=%0t got gr=%b fs=%b cp=%b slot=%0d x=%h/%h y=%h/%h want gr=%b fs=%b cp=%b slot=%0d x=%h/%h y=%h/%h",
                   $time, a.gr, a.fs, a.cp, a.slot, a.xi, a.xp, a.yi, a.yp,
                   e.gr, e.fs, e.cp, e.slot, e.xi, e.xp, e.yi, e.yp);
        end
      end
      if (frame_start === 1'b1) begin
        checks++;
        if (frame_q.size() == 0) begin
          errors++;
          $display("FAIL frame t=%0t got unexpected frame_start want none", $time);
        end else begin
          fe = frame_q.pop_front();
          fa = '{cur_slot, x_instr_flat, x_params_flat, y_instr_flat, y_params_flat};
          if (fa !== fe) begin
            errors++;
            $display("FAIL frame t=%0t got %h want %h", $time, fa, fe);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cfg_we     = 1'b0;
    cfg_commit = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input int s, input int ax, input int ix, input int op, input int pa);
    cfg_we    = 1'b1;
    cfg_slot  = 2'(s);
    cfg_axis  = 1'(ax);
    cfg_idx   = 2'(ix);
    cfg_instr = 3'(op);
    cfg_param = 8'(pa);
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  // Advance until the model sits in RUN with the given timer value.
  task automatic run_until_timer(input int t);
    int n = 0;
    while (!(m_mode == M_RUN && m_timer == t) && n < 100) begin
      tick();
      n++;
    end
    chk("reach_timer", (m_mode == M_RUN && m_timer == t) ? 1 : 0, 1);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; slot_count = 3'd2;
    cfg_we = 1'b0; cfg_slot = '0; cfg_axis = 1'b0; cfg_idx = '0;
    cfg_instr = '0; cfg_param = '0; cfg_commit = 1'b0;

    // Reset state.
    ticks(3);
    chk("rst_gen_reset", int'(gen_reset), 1);
    chk("rst_x_instr", int'(x_instr_flat), 0);
    reset = 1'b0;
    tick();

    // First program: slot0 x idx0 = JUMP 250, commit in IDLE, then enable.
    wr(0, 0, 0, 4, 250);
    tick();
    cfg_commit = 1'b1;
    tick();
    chk("idle_commit_cleared", int'(commit_pending), 0);
    enable = 1'b1;
    tick();
    chk("load_x_op", int'(x_instr_flat[2:0]), 4);
    chk("load_x_param", int'(x_params_flat[7:0]), 250);
    chk("load_gen_reset", int'(gen_reset), 1);
    tick();
    chk("run_gen_reset", int'(gen_reset), 0);
    chk("run_frame_start", int'(frame_start), 1);

    // Two-slot rotation.
    ticks(4 * (FC + 1));

    // Shadow-only writes to slot1, then a mid-frame commit.
    run_until_timer(2);
    wr(1, 1, 3, 2, 77);
    tick();
    wr(1, 0, 1, 3, 19);
    tick();
    ticks(3 * (FC + 1));
    run_until_timer(3);
    cfg_commit = 1'b1;
    tick();
    chk("pending_set", int'(commit_pending), 1);
    ticks(3 * (FC + 1));

    // Same-edge write and commit at a boundary: copy gets pre-write data.
    run_until_timer(FC - 1);
    cfg_commit = 1'b1;
    wr(0, 1, 2, 1, 200);
    tick();
    ticks(2 * (FC + 1));

    // Drop enable mid-frame, then restart.
    run_until_timer(1);
    ticks(4);
    enable = 1'b0;
    tick();
    chk("disable_gen_reset", int'(gen_reset), 1);
    chk("disable_slot_held", int'(cur_slot), m_slot);
    ticks(3);
    enable = 1'b1;
    tick();
    chk("reenable_slot0", int'(cur_slot), 0);
    ticks(2 * (FC + 1));

    // Reset mid-RUN with a same-cycle write; later commit shows all NOP.
    run_until_timer(2);
    reset = 1'b1;
    wr(2, 0, 0, 4, 99);
    cfg_commit = 1'b1;
    tick();
    reset = 1'b0;
    enable = 1'b0;
    tick();
    cfg_commit = 1'b1;
    tick();
    enable = 1'b1;
    tick();
    chk("post_reset_nop_x", int'(x_instr_flat), 0);
    chk("post_reset_nop_yp", int'(y_params_flat), 0);
    slot_count = 3'd3;
    ticks(3 * (FC + 1));

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 2) == 0)
        wr($urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
           $urandom_range(0, 4), $urandom_range(0, 255));
      cfg_commit = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 119) == 0) enable = ~enable;
      if ($urandom_range(0, 39) == 0) slot_count = 3'($urandom_range(0, 7));
      tick();
    end
    reset = 1'b0;
    ticks(2);

    chk("status_queue_drained", stat_q.size(), 0);
    chk("frame_queue_drained", frame_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
